// File: rtl/jtframe_multi_wait.sv
// Multi-channel CPU clock-enable gate: stalls each CPU on ROM waits or shared-device
// busy, counts cen pulses lost to ROM waits and replays them in idle bus cycles.
module jtframe_multi_wait #(
    parameter int               NCH      = 2,
    parameter int               DEVCNT   = 2,
    parameter int               CNTW     = 4,
    parameter logic [NCH-1:0]   REC_MASK = {NCH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        cen_in,
    output logic [NCH-1:0]        cen_out,
    output logic [NCH-1:0]        gate,
    input  logic [NCH-1:0]        rec_en,
    input  logic [DEVCNT-1:0]     dev_busy,
    input  logic [NCH-1:0]        rom_cs,
    input  logic [NCH-1:0]        rom_ok,
    output logic [NCH*CNTW-1:0]   miss_cnt,
    output logic [NCH-1:0]        lagging
);

    logic busy_any;

    assign busy_any = |dev_busy;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic            last_cs_q, last_cs_d;
        logic            locked_q, locked_d;
        logic            start_q, start_d;
        logic            cen_l_q, cen_l_d;
        logic [CNTW-1:0] miss_q, miss_d;
        logic            rom_posedge;
        logic            rom_bad;
        logic            stall_now;
        logic            rec;
        logic            gate_w;
        logic            cen_w;

        always_comb begin
            rom_posedge = rom_cs[g] & ~last_cs_q;
            rom_bad     = (rom_cs[g] & ~rom_ok[g]) | rom_posedge;
            stall_now   = rom_bad | busy_any;
            gate_w      = ~(stall_now | locked_q);
            // Replay only in a free slot: no real cen now, none last cycle, channel running
            rec         = REC_MASK[g] & (|miss_q) & ~cen_in[g] & rec_en[g]
                          & ~cen_l_q & gate_w;
            cen_w       = (cen_in[g] & gate_w) | rec;
        end

        always_comb begin
            last_cs_d = rom_cs[g];
            locked_d  = stall_now;
            start_d   = start_q | ~stall_now;
            cen_l_d   = cen_w;
            miss_d    = miss_q;
            if (!start_q) begin
                miss_d = '0;
            end else if (cen_in[g] && !gate_w && !busy_any) begin
                if (!(&miss_q)) begin
                    miss_d = miss_q + CNTW'(1);
                end
            end else if (rec) begin
                miss_d = miss_q - CNTW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                last_cs_q <= 1'b1;
                locked_q  <= 1'b0;
                start_q   <= 1'b0;
                cen_l_q   <= 1'b0;
                miss_q    <= '0;
            end else begin
                last_cs_q <= last_cs_d;
                locked_q  <= locked_d;
                start_q   <= start_d;
                cen_l_q   <= cen_l_d;
                miss_q    <= miss_d;
            end
        end

        assign gate[g]                   = gate_w;
        assign cen_out[g]                = cen_w;
        assign miss_cnt[g*CNTW +: CNTW]  = miss_q;
        assign lagging[g]                = |miss_q;
    end

endmodule
